// File: rtl/risc16_dbus_pkg.sv
// Shared constants for the risc16 data-bus slave: MMIO offsets, STATUS bit
// positions and the address region select.
package risc16_dbus_pkg;

  localparam logic [7:0] OFS_TXDATA = 8'h00;
  localparam logic [7:0] OFS_STATUS = 8'h02;
  localparam logic [7:0] OFS_CYCLE  = 8'h04;

  localparam int STS_OVF   = 15;
  localparam int STS_FULL  = 9;
  localparam int STS_EMPTY = 8;

  typedef enum logic [1:0] {
    SEL_RAM,
    SEL_MMIO,
    SEL_NONE
  } sel_e;

  // Register match on the word offset; the byte bit of the address is ignored.
  function automatic logic reg_hit(input logic [7:0] ofs, input logic [7:0] reg_ofs);
    return ofs[7:1] == reg_ofs[7:1];
  endfunction

endpackage

// File: rtl/risc16_byte_fifo.sv
// Synchronous byte FIFO with occupancy count. A push into a full FIFO is only
// accepted when a pop frees the head slot in the same cycle.
module risc16_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign dout  = empty ? 8'h00 : mem[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/risc16_dbus_ctrl.sv
// Data-bus slave for the risc16 EX stage: byte-lane scratchpad RAM plus an MMIO
// window (TX FIFO, STATUS, CYCLE). Cycle counter enabled by RISC16_DBUS_CYCLE_CNT_EN.
module risc16_dbus_ctrl
  import risc16_dbus_pkg::*;
#(
  parameter int          RAM_WORDS = 512,
  parameter int          TX_DEPTH  = 8,
  parameter logic [15:0] MMIO_BASE = 16'hFF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] daddr,
  input  logic [15:0] ddout,
  output logic [15:0] ddin,
  input  logic        doe,
  input  logic        dwe0,
  input  logic        dwe1,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(TX_DEPTH) + 1;

  sel_e          sel;
  logic [AW-1:0] widx;
  logic          wr_any, mmio_wr;
  logic          push, pop;
  logic [7:0]    push_byte;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    count8;
  logic          ovf_q, ovf_d;
  logic [15:0]   status_word;
  logic [15:0]   cycle_rd;
  logic [15:0]   rdata;
  logic          unused;

  logic [7:0] mem_hi [RAM_WORDS];
  logic [7:0] mem_lo [RAM_WORDS];

  assign unused = daddr[0];
  assign widx   = daddr[AW:1];
  assign wr_any = dwe0 | dwe1;

  always_comb begin
    if ({1'b0, daddr} < 17'(2 * RAM_WORDS))  sel = SEL_RAM;
    else if (daddr[15:8] == MMIO_BASE[15:8]) sel = SEL_MMIO;
    else                                     sel = SEL_NONE;
  end

  assign mmio_wr = (sel == SEL_MMIO) && wr_any;

  always_ff @(posedge clk) begin
    if (sel == SEL_RAM && dwe0) mem_hi[widx] <= ddout[15:8];
    if (sel == SEL_RAM && dwe1) mem_lo[widx] <= ddout[7:0];
  end

  assign push      = mmio_wr && reg_hit(daddr[7:0], OFS_TXDATA);
  assign push_byte = dwe1 ? ddout[7:0] : ddout[15:8];
  assign tx_valid  = !fifo_empty;
  assign pop       = tx_valid && tx_ready && !rst;

  risc16_byte_fifo #(.DEPTH(TX_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_byte),
    .dout  (tx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Set is evaluated last so an overflow in the clearing cycle is not lost.
  always_comb begin
    ovf_d = ovf_q;
    if (mmio_wr && reg_hit(daddr[7:0], OFS_STATUS) && ddout[15]) ovf_d = 1'b0;
    if (push && fifo_full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  always_comb begin
    count8 = '0;
    count8[CW-1:0] = fifo_count;
    status_word = '0;
    status_word[STS_OVF]   = ovf_q;
    status_word[STS_FULL]  = fifo_full;
    status_word[STS_EMPTY] = fifo_empty;
    status_word[7:0]       = count8;
  end

`ifdef RISC16_DBUS_CYCLE_CNT_EN
  logic [15:0] cycle_q, cycle_d;

  always_comb begin
    cycle_d = cycle_q + 16'd1;
    if (mmio_wr && reg_hit(daddr[7:0], OFS_CYCLE)) cycle_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cycle_q <= '0;
    else     cycle_q <= cycle_d;
  end

  assign cycle_rd = cycle_q;
`else
  assign cycle_rd = '0;
`endif

  always_comb begin
    rdata = '0;
    if (doe) begin
      case (sel)
        SEL_RAM:  rdata = {mem_hi[widx], mem_lo[widx]};
        SEL_MMIO: begin
          if (reg_hit(daddr[7:0], OFS_STATUS))     rdata = status_word;
          else if (reg_hit(daddr[7:0], OFS_CYCLE)) rdata = cycle_rd;
        end
        default:  rdata = '0;
      endcase
    end
  end

  assign ddin = rdata;

endmodule

// File: tb/tb_risc16_dbus_ctrl.sv
// Directed bench for risc16_dbus_ctrl: RAM/decode vector table, then hand
// sequences for the TX FIFO, overflow, reset flush and the cycle counter.
module tb_risc16_dbus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] daddr, ddout, ddin;
  logic        doe, dwe0, dwe1;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_data;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        oe, w0, w1;
    logic [15:0] exp_ddin;
  } vec_t;

  vec_t vecs[$];

  risc16_dbus_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .daddr    (daddr),
    .ddout    (ddout),
    .ddin     (ddin),
    .doe      (doe),
    .dwe0     (dwe0),
    .dwe1     (dwe1),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %04h want %04h", name, act, exp);
    end
  endtask

  task automatic drv(input logic [15:0] a, input logic [15:0] d,
                     input logic oe, input logic w0, input logic w1);
    daddr = a; ddout = d; doe = oe; dwe0 = w0; dwe1 = w1;
  endtask

  task automatic add(input logic [15:0] a, input logic [15:0] d,
                     input logic oe, input logic w0, input logic w1, input logic [15:0] e);
    vec_t v;
    v.addr = a; v.wdata = d; v.oe = oe; v.w0 = w0; v.w1 = w1; v.exp_ddin = e;
    vecs.push_back(v);
  endtask

  task automatic rd_status(input string name, input logic [15:0] e);
    drv(16'hFF02, 16'h0000, 1'b1, 1'b0, 1'b0);
    #1 chk(name, ddin, e);
  endtask

  initial begin
    rst = 1'b1; tx_ready = 1'b0;
    drv(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    #1 chk("rst_ddin_noe", ddin, 16'h0000);
    chk("rst_tx_valid", {15'd0, tx_valid}, 16'h0000);
    chk("rst_tx_data", {8'd0, tx_data}, 16'h0000);
    rd_status("rst_status", 16'h0100);
    @(negedge clk);
    rst = 1'b0;

    add(16'h0010, 16'hABCD, 1'b0, 1'b1, 1'b1, 16'h0000);
    add(16'h0010, 16'h0000, 1'b1, 1'b0, 1'b0, 16'hABCD);
    add(16'h0010, 16'h12FF, 1'b0, 1'b1, 1'b0, 16'h0000);
    add(16'h0010, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h12CD);
    add(16'h0011, 16'hFF34, 1'b0, 1'b0, 1'b1, 16'h0000);
    add(16'h0010, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h1234);
    add(16'h0011, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h1234);
    add(16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    add(16'h8000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000);
    add(16'h8000, 16'h5555, 1'b0, 1'b1, 1'b1, 16'h0000);
    add(16'h8000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000);
    add(16'h0010, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h1234);
    add(16'h0000, 16'hBEEF, 1'b0, 1'b1, 1'b1, 16'h0000);
    add(16'h03FE, 16'h0102, 1'b0, 1'b1, 1'b1, 16'h0000);
    add(16'h03FE, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0102);
    add(16'h0400, 16'h9999, 1'b0, 1'b1, 1'b1, 16'h0000);
    add(16'h0400, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000);
    add(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'hBEEF);
    add(16'hFF02, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0100);
    add(16'hFF06, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000);
    add(16'hFF00, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000);

    foreach (vecs[i]) begin
      drv(vecs[i].addr, vecs[i].wdata, vecs[i].oe, vecs[i].w0, vecs[i].w1);
      #1 chk($sformatf("vec%0d_ddin", i), ddin, vecs[i].exp_ddin);
      chk($sformatf("vec%0d_txv", i), {15'd0, tx_valid}, 16'h0000);
      @(negedge clk);
    end

    // Two pushes: odd lane, then even lane only
    drv(16'hFF00, 16'h0041, 1'b0, 1'b0, 1'b1); @(negedge clk);
    drv(16'hFF00, 16'h4200, 1'b0, 1'b1, 1'b0); @(negedge clk);
    rd_status("ab_status", 16'h0002);
    chk("ab_txv", {15'd0, tx_valid}, 16'h0001);
    chk("ab_head", {8'd0, tx_data}, 16'h0041);
    drv(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    tx_ready = 1'b1;
    @(negedge clk);
    #1 chk("ab_pop1", {8'd0, tx_data}, 16'h0042);
    @(negedge clk);
    tx_ready = 1'b0;
    rd_status("ab_drained", 16'h0100);
    chk("ab_txv0", {15'd0, tx_valid}, 16'h0000);

    // Overflow: 9 pushes into 8 entries
    for (int i = 0; i < 9; i++) begin
      drv(16'hFF00, 16'(8'h50 + i), 1'b0, 1'b0, 1'b1);
      @(negedge clk);
    end
    rd_status("ovf_status", 16'h8208);
    chk("ovf_head", {8'd0, tx_data}, 16'h0050);
    drv(16'hFF02, 16'h8000, 1'b0, 1'b1, 1'b1); @(negedge clk);
    rd_status("ovf_clear", 16'h0208);

    // Full: push and pop together
    drv(16'hFF00, 16'h0077, 1'b0, 1'b0, 1'b1);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    rd_status("fullpp_status", 16'h0208);
    chk("fullpp_head", {8'd0, tx_data}, 16'h0051);

    drv(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1 chk($sformatf("drain%0d", i), {8'd0, tx_data}, (i < 7) ? 16'(8'h51 + i) : 16'h0077);
      @(negedge clk);
    end
    tx_ready = 1'b0;
    rd_status("drain_status", 16'h0100);

    // Reset flush with 3 bytes queued
    for (int i = 0; i < 3; i++) begin
      drv(16'hFF00, 16'(8'h60 + i), 1'b0, 1'b0, 1'b1);
      @(negedge clk);
    end
    rd_status("pre_rst_status", 16'h0003);
    drv(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; tx_ready = 1'b0;
    #1 chk("flush_txv", {15'd0, tx_valid}, 16'h0000);
    chk("flush_txdata", {8'd0, tx_data}, 16'h0000);
    rd_status("flush_status", 16'h0100);

    // Cycle counter: 5 edges after reset release
    drv(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    drv(16'hFF04, 16'h0000, 1'b1, 1'b0, 1'b0);
`ifdef RISC16_DBUS_CYCLE_CNT_EN
    #1 chk("cycle5", ddin, 16'h0005);
`else
    #1 chk("cycle_off", ddin, 16'h0000);
`endif
    drv(16'hFF04, 16'hFFFF, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    drv(16'hFF04, 16'h0000, 1'b1, 1'b0, 1'b0);
    #1 chk("cycle_cleared", ddin, 16'h0000);
    @(negedge clk);
`ifdef RISC16_DBUS_CYCLE_CNT_EN
    #1 chk("cycle_after_clr", ddin, 16'h0001);
`else
    #1 chk("cycle_off_wr", ddin, 16'h0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
